// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// controller state encoding and the default operand width.
package mult_div_unit_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/mult_div_unit_md_iter_core.sv
// Unsigned one-bit-per-cycle datapath: radix-2 shift-add multiply or
// restoring shift-subtract divide on a shared 2*WIDTH accumulator.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic               r_mode;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;

  // Multiply: low half holds the multiplier bits still to consume; the
  // upper half plus a carry bit accumulates and shifts right each step.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: shift the next dividend bit into the remainder and subtract;
  // a clear borrow bit means the subtraction is kept and a 1 enters the quotient.
  assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
  assign w_div_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_b    <= '0;
      r_mode <= 1'b0;
    end else if (i_load) begin
      r_acc  <= {{WIDTH{1'b0}}, i_a};
      r_b    <= i_b;
      r_mode <= i_mode;
    end else if (i_step) begin
      r_acc  <= r_mode ? w_div_next : w_mul_next;
    end
  end

  assign o_hi = r_acc[2*WIDTH-1:WIDTH];
  assign o_lo = r_acc[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO unit: sign handling, controller FSM, iteration counter and the
// architectural HI/LO registers around the unsigned iterative core.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is accepted on any edge where busy=0 (IDLE or DONE);
  // starts while busy=1 are dropped. done pulses for one cycle once HI/LO
  // hold the result, and a start in that same cycle launches the next op.
  md_state_e r_state, w_next;

  logic [CW-1:0]      r_cnt;
  logic               r_busy, r_done;
  logic               r_is_div, r_neg_q, r_neg_r, r_dz;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_idle, w_accept, w_step;
  logic               w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_abs, w_b_abs;
  logic [WIDTH-1:0]   w_c_hi, w_c_lo;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix, w_rem_fix;

  assign w_idle   = (r_state == IDLE) || (r_state == DONE);
  assign w_accept = w_idle && start;
  assign w_step   = (r_state == RUN);

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & op_a[WIDTH-1];
  assign w_b_neg  = w_signed & op_b[WIDTH-1];
  assign w_a_abs  = w_a_neg ? -op_a : op_a;
  assign w_b_abs  = w_b_neg ? -op_b : op_b;

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_accept),
    .i_step (w_step),
    .i_mode (op[1]),
    .i_a    (w_a_abs),
    .i_b    (w_b_abs),
    .o_hi   (w_c_hi),
    .o_lo   (w_c_lo)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == CW'(1)) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == RUN) || (w_next == FIX);
      r_done  <= (w_next == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= CW'(WIDTH);
      r_is_div <= op[1];
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_dz     <= (op_b == '0);
    end else if (w_step) begin
      r_cnt    <= r_cnt - CW'(1);
    end
  end

  // Magnitudes of the most-negative value are exact in unsigned form, so a
  // plain negate on the way out yields the exact signed result.
  assign w_prod     = {w_c_hi, w_c_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quot_fix = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? -w_c_lo : w_c_lo);
  assign w_rem_fix  = r_neg_r ? -w_c_hi : w_c_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == FIX) begin
      r_hi <= r_is_div ? w_rem_fix  : w_prod_fix[2*WIDTH-1:WIDTH];
      r_lo <= r_is_div ? w_quot_fix : w_prod_fix[WIDTH-1:0];
    end else if (w_idle && !start) begin
      if (hi_we) r_hi <= wdata;
      if (lo_we) r_lo <= wdata;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations compared against a 64-bit arithmetic reference model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  op_a = '0, op_b = '0, wdata = '0;
  logic          hi_we = 1'b0, lo_we = 1'b0;
  logic          busy, done;
  logic [W-1:0]  hi, lo;
  logic [1:0]    dbg_state;

  int n_chk  = 0;
  int n_pass = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi = '0, m_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: {HI, LO} from plain 64-bit arithmetic on the operands.
  function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      MD_MULT:  begin q = sa * sb; return q; end
      MD_MULTU: begin p = ua * ub; return p; end
      default: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        if (o == MD_DIV) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        p = ua / ub;
        q = longint'(ua % ub);
        return {q[31:0], p[31:0]};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, optionally poking start+mthi mid-run or mthi alongside start.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke, input bit with_we);
    int lat, busy_cnt;
    bit stable_ok;
    logic [2*W-1:0] e;
    exp_q.push_back(model(o, a, b));
    op = o; op_a = a; op_b = b; start = 1'b1;
    if (with_we) begin hi_we = 1'b1; wdata = 32'h1234; end
    tick();
    lat = 1; busy_cnt = 0; stable_ok = 1'b1;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (hi !== m_hi || lo !== m_lo) stable_ok = 1'b0;
      start = 1'b0; hi_we = 1'b0;
      if (poke && lat == 5) begin
        start = 1'b1; hi_we = 1'b1; wdata = 32'h1234;
        op = MD_MULTU; op_a = 32'h7; op_b = 32'h9;
      end
      tick();
      lat++;
    end
    start = 1'b0; hi_we = 1'b0;
    chk("latency", 64'(lat), 64'(W + 2));
    chk("busy_cycles", 64'(busy_cnt), 64'(W + 1));
    chk("hilo_stable", 64'(stable_ok), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    if (exp_q.size() == 0) chk("exp_q_empty", 64'd1, 64'd0);
    else begin
      e = exp_q.pop_front();
      chk("hi", 64'(hi), 64'(e[2*W-1:W]));
      chk("lo", 64'(lo), 64'(e[W-1:0]));
      m_hi = e[2*W-1:W];
      m_lo = e[W-1:0];
    end
    tick();
    chk("done_pulse_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic reset_mid_run();
    bit saw_done;
    op = MD_MULT; op_a = 32'h1234_5678; op_b = 32'hFFFF_0001; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    saw_done = 1'b0;
    repeat (45) begin
      if (done || busy) saw_done = 1'b1;
      tick();
    end
    chk("rst_no_done", 64'(saw_done), 64'd0);
  endtask

  initial begin
    logic [1:0]   r_op;
    logic [W-1:0] r_a, r_b;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'(IDLE));

    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd5,        0, 0);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 0, 0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,        0, 0);
    run_op(MD_DIVU,  32'd100,       32'd7,        0, 0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd0,        0, 0);
    run_op(MD_DIVU,  32'd5,         32'd0,        0, 0);

    // mtlo just after done
    lo_we = 1'b1; wdata = 32'hABCD;
    tick();
    lo_we = 1'b0;
    m_lo = 32'hABCD;
    chk("mtlo_lo", 64'(lo), 64'(m_lo));
    chk("mtlo_hi_kept", 64'(hi), 64'(m_hi));

    // mthi and mtlo together from IDLE
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    m_hi = 32'hCAFE_F00D; m_lo = 32'hCAFE_F00D;
    chk("mthi_both_hi", 64'(hi), 64'(m_hi));
    chk("mthi_both_lo", 64'(lo), 64'(m_lo));

    run_op(MD_MULTU, 32'hDEAD_BEEF, 32'h0001_0003, 1, 0);
    run_op(MD_DIVU,  32'd100,       32'd7,         0, 1);

    reset_mid_run();
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, 0, 0);

    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 20));
      run_op(r_op, r_a, r_b, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
